sprite_collision_detector: RTL and testbench
============================================

SPRITE_COLLISION_DETECTOR -- requirements
Module: sprite_collision_detector

Interface
REQ-001 Parameter WALL_R, default 4'h0, wall colour red component.
REQ-002 Parameter WALL_G, default 4'h0, wall colour green component.
REQ-003 Parameter WALL_B, default 4'hF, wall colour blue component.
REQ-004 Parameter TIMEOUT, default 15, maximum cycles to wait for rd_valid per probe.
REQ-005 frame_clk  in  1  clock; all state changes on rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 keycode  in  8  keyboard code; 8'h04 A(left), 8'h07 D(right), 8'h16 S(down), 8'h1A W(up).
REQ-008 spriteX, spriteY  in  10 each  sprite centre position.
REQ-009 spriteS  in  10  sprite half-size.
REQ-010 rd_req  out  1  background pixel read request.
REQ-011 rd_x, rd_y  out  10 each  pixel coordinate being read.
REQ-012 rd_valid  in  1  read data valid; sampled only while rd_req=1.
REQ-013 red, green, blue  in  4 each  pixel colour, valid when rd_valid=1.
REQ-014 collision  out  1  registered: leading-edge probe hit wall or screen bound.
REQ-015 busy  out  1  high while a probe sweep is in progress.

Function
REQ-016 The block SHALL use states IDLE, PROBE, DONE.
REQ-017 In IDLE, a direction keycode SHALL latch keycode, spriteX, spriteY, spriteS, clear hit flag, set k=0, enter PROBE.
REQ-018 In IDLE, a non-direction keycode SHALL set collision=0 and remain in IDLE.
REQ-019 Probe k (0..4) SHALL use offset o=(k-2)*(S>>1), signed 11-bit arithmetic on latched values.
REQ-020 Probe coordinates: D x=X+S+1,y=Y+o; A x=X-S-1,y=Y+o; S y=Y+S+1,x=X+o; W y=Y-S-1,x=X+o.
REQ-021 A probe with x outside 0..639 or y outside 0..479 SHALL set hit, issue no read, and advance k after one cycle.
REQ-022 An in-bounds probe SHALL drive rd_req=1 with rd_x/rd_y held stable until rd_valid=1 is sampled.
REQ-023 rd_valid=1 in the first cycle rd_req is high SHALL be accepted (single-cycle probe).
REQ-024 On acceptance, {red,green,blue}=={WALL_R,WALL_G,WALL_B} SHALL set hit; rd_req drops next cycle unless next probe is in-bounds.
REQ-025 If rd_valid is not seen within TIMEOUT cycles of rd_req rising, the probe SHALL be treated as a hit and k advanced.
REQ-026 After probe 4 completes, the block SHALL enter DONE; DONE SHALL load collision<=hit and return to IDLE next edge.
REQ-027 collision SHALL hold its value throughout PROBE and change only in DONE or per REQ-018.
REQ-028 Keycode and sprite input changes during PROBE/DONE SHALL be ignored; new key sampled only in IDLE.
REQ-029 busy SHALL be 1 in PROBE and DONE, 0 in IDLE.
REQ-030 Minimum latency: key sampled at edge 0, collision updated at edge 6 (five single-cycle probes).
REQ-031 spriteS=0 SHALL yield five probes at the same coordinate; behaviour otherwise unchanged.

Reset
REQ-032 Reset SHALL asynchronously force IDLE, k=0, hit=0, collision=0, busy=0, rd_req=0, rd_x=0, rd_y=0.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep; no collision update from the aborted sweep.
REQ-034 After Reset deasserts, the first direction key SHALL start a fresh sweep.

Verification
REQ-035 X=320,Y=240,S=30,key 8'h07, responder returns black with rd_valid same cycle -> probes x=351, y=210,225,240,255,270; collision=0 at edge 6; busy low after.
REQ-036 Same, responder returns 4'h0/4'h0/4'hF at y=255 only -> collision=1 at edge 6.
REQ-037 X=620,Y=240,S=30,key 8'h07 -> all probes x=651 out of bounds, no rd_req, collision=1 at edge 6.
REQ-038 Key 8'h1A, responder never asserts rd_valid -> each probe held 15 cycles, rd_y=209, collision=1 after sweep.
REQ-039 Key 8'h04, Reset pulsed during probe 2 -> collision=0, busy=0, rd_req=0 immediately; next key restarts sweep from k=0.
REQ-040 collision=1, keycode set to 8'h00 in IDLE -> collision=0 next edge, no rd_req.

Source files
------------

// File: rtl/sprite_collision_detector.sv
// Sprite collision detector: on a direction key, sweeps five probe points
// along the sprite's leading edge, reads the background colour under each
// and flags a collision if any probe lands on the wall colour or off-screen.
module sprite_collision_detector #(
   parameter logic [3:0] WALL_R  = 4'h0,
   parameter logic [3:0] WALL_G  = 4'h0,
   parameter logic [3:0] WALL_B  = 4'hF,
   parameter int         TIMEOUT = 15
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic [9:0] spriteX,
   input  logic [9:0] spriteY,
   input  logic [9:0] spriteS,
   output logic       rd_req,
   output logic [9:0] rd_x,
   output logic [9:0] rd_y,
   input  logic       rd_valid,
   input  logic [3:0] red,
   input  logic [3:0] green,
   input  logic [3:0] blue,
   output logic       collision,
   output logic       busy
);

   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_W = 8'h1A;
   localparam int         CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

   state_t            state;
   state_t            next_state;
   logic [7:0]        key_q;
   logic [9:0]        x_q;
   logic [9:0]        y_q;
   logic [9:0]        s_q;
   logic [2:0]        k;
   logic              hit;
   logic [CW-1:0]     wait_cnt;

   logic              is_dir;
   logic signed [10:0] sx;
   logic signed [10:0] sy;
   logic signed [10:0] ss;
   logic signed [10:0] half;
   logic signed [10:0] off;
   logic signed [10:0] px;
   logic signed [10:0] py;
   logic              in_bounds;
   logic              is_wall;
   logic              timed_out;
   logic              probe_done;
   logic              probe_hit;

   assign is_dir = (keycode == KEY_A) || (keycode == KEY_D) ||
                   (keycode == KEY_S) || (keycode == KEY_W);

   // Probe point for the current k: offset along the edge is (k-2)*(S/2),
   // pushed one pixel beyond the sprite's edge in the direction of travel.
   always_comb begin
      sx   = signed'({1'b0, x_q});
      sy   = signed'({1'b0, y_q});
      ss   = signed'({1'b0, s_q});
      half = signed'({2'b00, s_q[9:1]});
      off  = 11'sd0;
      px   = sx;
      py   = sy;
      case (k)
         3'd0:    off = -(half + half);
         3'd1:    off = -half;
         3'd2:    off = 11'sd0;
         3'd3:    off = half;
         default: off = half + half;
      endcase
      case (key_q)
         KEY_D: begin
            px = sx + ss + 11'sd1;
            py = sy + off;
         end
         KEY_A: begin
            px = sx - ss - 11'sd1;
            py = sy + off;
         end
         KEY_S: begin
            px = sx + off;
            py = sy + ss + 11'sd1;
         end
         default: begin
            px = sx + off;
            py = sy - ss - 11'sd1;
         end
      endcase
   end

   // Bounds check, wall colour match and per-probe completion; an
   // off-screen probe finishes in one cycle without touching the read port.
   always_comb begin
      in_bounds  = !px[10] && (px <= 11'sd639) && !py[10] && (py <= 11'sd479);
      is_wall    = ({red, green, blue} == {WALL_R, WALL_G, WALL_B});
      timed_out  = (wait_cnt == CW'(TIMEOUT - 1));
      rd_req     = (state == PROBE) && in_bounds;
      rd_x       = rd_req ? px[9:0] : 10'd0;
      rd_y       = rd_req ? py[9:0] : 10'd0;
      probe_done = (state == PROBE) && (!in_bounds || rd_valid || timed_out);
      probe_hit  = !in_bounds || (rd_valid ? is_wall : 1'b1);
      busy       = (state != IDLE);
   end

   // State register; reset abandons any sweep in flight.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next state: a direction key starts a sweep, five probes, then one
   // DONE cycle to publish the result.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (is_dir) next_state = PROBE;
         PROBE:   if (probe_done && (k == 3'd4)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Sweep datapath: latch the sprite snapshot, accumulate hits per probe,
   // time out silent reads, and update collision only when a sweep ends or
   // a non-direction key is seen while idle.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         key_q     <= 8'h00;
         x_q       <= 10'd0;
         y_q       <= 10'd0;
         s_q       <= 10'd0;
         k         <= 3'd0;
         hit       <= 1'b0;
         wait_cnt  <= '0;
         collision <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (is_dir) begin
                  key_q    <= keycode;
                  x_q      <= spriteX;
                  y_q      <= spriteY;
                  s_q      <= spriteS;
                  k        <= 3'd0;
                  hit      <= 1'b0;
                  wait_cnt <= '0;
               end else begin
                  collision <= 1'b0;
               end
            end
            PROBE: begin
               if (probe_done) begin
                  hit      <= hit | probe_hit;
                  k        <= k + 3'd1;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE:    collision <= hit;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_collision_detector.sv
// Scoreboard bench for sprite_collision_detector: a reference model pushes
// the expected probe sequence and sweep result, a background responder
// answers reads, and each cycle pops and compares against the DUT.
module tb_sprite_collision_detector;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic [7:0] keycode;
   logic [9:0] spriteX;
   logic [9:0] spriteY;
   logic [9:0] spriteS;
   logic       rd_req;
   logic [9:0] rd_x;
   logic [9:0] rd_y;
   logic       rd_valid;
   logic [3:0] red;
   logic [3:0] green;
   logic [3:0] blue;
   logic       collision;
   logic       busy;

   int n_compared   = 0;
   int n_mismatched = 0;
   bit exp_coll_now = 1'b0;

   typedef struct {
      int x;
      int y;
      bit inb;
   } probe_t;

   probe_t probe_q[$];
   bit     coll_q[$];

   sprite_collision_detector dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .keycode   (keycode),
      .spriteX   (spriteX),
      .spriteY   (spriteY),
      .spriteS   (spriteS),
      .rd_req    (rd_req),
      .rd_x      (rd_x),
      .rd_y      (rd_y),
      .rd_valid  (rd_valid),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .collision (collision),
      .busy      (busy)
   );

   // 10 ns frame clock
   always #5 frame_clk = ~frame_clk;

   // Runaway guard
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // mode 0: reads return bg; mode 1: wall colour at (wall_x,wall_y), else bg;
   // mode 2: reads never acknowledged. abort_at >= 0 pulses Reset in that probe.
   task automatic applyStimulus(input logic [7:0] key, input int sx, input int sy,
                                input int ss, input int mode, input int wall_x,
                                input int wall_y, input logic [11:0] bg,
                                input int abort_at);
      bit exp_hit = 1'b0;
      for (int k = 0; k < 5; k++) begin
         probe_t p;
         int     o;
         o = (k - 2) * (ss >> 1);
         case (key)
            8'h07:   begin p.x = sx + ss + 1; p.y = sy + o; end
            8'h04:   begin p.x = sx - ss - 1; p.y = sy + o; end
            8'h16:   begin p.x = sx + o;      p.y = sy + ss + 1; end
            default: begin p.x = sx + o;      p.y = sy - ss - 1; end
         endcase
         p.inb = (p.x >= 0) && (p.x <= 639) && (p.y >= 0) && (p.y <= 479);
         if (!p.inb || mode == 2 || (mode == 1 && p.x == wall_x && p.y == wall_y))
            exp_hit = 1'b1;
         probe_q.push_back(p);
      end
      coll_q.push_back(exp_hit);

      keycode = key;
      spriteX = 10'(sx);
      spriteY = 10'(sy);
      spriteS = 10'(ss);
      @(posedge frame_clk); #1;
      keycode = 8'h16;
      spriteX = 10'd5;
      spriteY = 10'd5;
      spriteS = 10'd0;

      for (int k = 0; k < 5; k++) begin
         probe_t p;
         int     hold;
         p = probe_q.pop_front();
         if (k == abort_at) begin
            Reset = 1'b1;
            #1;
            checkOutput("abort collision", collision, 0);
            checkOutput("abort busy", busy, 0);
            checkOutput("abort rd_req", rd_req, 0);
            checkOutput("abort rd_x", rd_x, 0);
            keycode  = 8'h00;
            rd_valid = 1'b0;
            @(negedge frame_clk);
            Reset = 1'b0;
            @(posedge frame_clk); #1;
            probe_q.delete();
            coll_q.delete();
            exp_coll_now = 1'b0;
            return;
         end
         hold = (p.inb && mode == 2) ? 15 : 1;
         for (int c = 0; c < hold; c++) begin
            checkOutput($sformatf("p%0d.%0d busy", k, c), busy, 1);
            checkOutput($sformatf("p%0d.%0d rd_req", k, c), rd_req, 32'(p.inb));
            if (c == 0)
               checkOutput($sformatf("p%0d collision held", k), collision, 32'(exp_coll_now));
            if (p.inb && (c == 0 || c == hold - 1)) begin
               checkOutput($sformatf("p%0d.%0d rd_x", k, c), rd_x, p.x);
               checkOutput($sformatf("p%0d.%0d rd_y", k, c), rd_y, p.y);
            end
            rd_valid = 1'b0;
            {red, green, blue} = 12'h000;
            if (rd_req && mode != 2) begin
               rd_valid = 1'b1;
               if (mode == 1 && int'(rd_x) == wall_x && int'(rd_y) == wall_y)
                  {red, green, blue} = 12'h00F;
               else
                  {red, green, blue} = bg;
            end
            @(posedge frame_clk); #1;
         end
      end
      rd_valid = 1'b0;

      checkOutput("done busy", busy, 1);
      checkOutput("done rd_req", rd_req, 0);
      checkOutput("done collision held", collision, 32'(exp_coll_now));
      @(posedge frame_clk); #1;
      exp_coll_now = coll_q.pop_front();
      checkOutput("sweep collision", collision, 32'(exp_coll_now));
      checkOutput("idle busy", busy, 0);
      checkOutput("idle rd_req", rd_req, 0);
   endtask

   // Stimulus sequence
   initial begin
      Reset    = 1'b1;
      keycode  = 8'h00;
      spriteX  = 10'd0;
      spriteY  = 10'd0;
      spriteS  = 10'd0;
      rd_valid = 1'b0;
      {red, green, blue} = 12'h000;
      #2;
      checkOutput("reset collision", collision, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset rd_req", rd_req, 0);
      checkOutput("reset rd_x", rd_x, 0);
      checkOutput("reset rd_y", rd_y, 0);
      @(negedge frame_clk);
      Reset = 1'b0;
      @(posedge frame_clk); #1;

      applyStimulus(8'h07, 320, 240, 30, 0, 0, 0, 12'h000, -1);
      applyStimulus(8'h07, 320, 240, 30, 1, 351, 255, 12'h000, -1);

      keycode = 8'h00;
      @(posedge frame_clk); #1;
      exp_coll_now = 1'b0;
      checkOutput("nonkey collision", collision, 0);
      checkOutput("nonkey rd_req", rd_req, 0);
      checkOutput("nonkey busy", busy, 0);

      applyStimulus(8'h16, 100, 100, 0, 0, 0, 0, 12'h00E, -1);
      applyStimulus(8'h07, 620, 240, 30, 0, 0, 0, 12'h000, -1);
      applyStimulus(8'h07, 320, 470, 20, 0, 0, 0, 12'h000, -1);
      applyStimulus(8'h04, 30, 240, 29, 0, 0, 0, 12'h01F, -1);
      applyStimulus(8'h1A, 320, 240, 30, 2, 0, 0, 12'h000, -1);
      applyStimulus(8'h04, 320, 240, 30, 0, 0, 0, 12'h000, 2);
      applyStimulus(8'h04, 320, 240, 30, 1, 289, 240, 12'h000, -1);

      keycode = 8'h00;
      @(posedge frame_clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
